// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx between NUM_REQ byte
// streams. A granted requester keeps the transmitter until it sends a byte
// marked req_last, or until it leaves req_valid low in SEND for TIMEOUT cycles.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | no owner; round-robin search from rr_ptr for a valid requester
// S_SEND      | owner selected; issue tx_start when its byte is valid and uart idle
// S_WAIT_BUSY | byte handed to uart_tx; waiting for tx_busy to rise
// S_WAIT_DONE | frame in flight; on tx_busy fall, release (last) or back to SEND

module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8,
   parameter int TIMEOUT   = 4096
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
   input  logic [NUM_REQ-1:0]             req_last,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           tx_start,
   output logic [DATA_BITS-1:0]           tx_data,
   input  logic                           tx_busy,
   output logic                           pkt_done_tick,
   output logic                           timeout_tick
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SW = IW + 1;
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   // Terminal count of the idle counter; unused when the timeout is disabled.
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_SEND      = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [NUM_REQ-1:0]   grant_r, grant_nxt;
   logic [IW-1:0]        gidx, gidx_nxt;
   logic [IW-1:0]        rr_ptr, rr_nxt;
   logic [CW-1:0]        idle_cnt, idle_nxt;
   logic                 last_r, last_nxt;

   logic                 pick_found;
   logic [IW-1:0]        pick_idx;
   logic [SW-1:0]        pick_sum;
   logic [DATA_BITS-1:0] sel_data;
   logic                 sel_valid;
   logic                 sel_last;
   logic [IW-1:0]        next_ptr;

   assign grant    = grant_r;
   // After a release the requester just served drops to lowest priority.
   assign next_ptr = (gidx == IDX_MAX) ? '0 : gidx + IW'(1);

   // Round-robin search: first valid requester at or after rr_ptr, with wrap.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pick_sum = {1'b0, rr_ptr} + SW'(k);
         if (pick_sum >= SW'(NUM_REQ)) begin
            pick_sum = pick_sum - SW'(NUM_REQ);
         end
         if (!pick_found && req_valid[pick_sum[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = pick_sum[IW-1:0];
         end
      end
   end

   // Mux out the owner's byte, valid and last; other requesters are ignored.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gidx == IW'(i)) begin
            sel_data  = req_data[i*DATA_BITS +: DATA_BITS];
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
         end
      end
   end

   // Next-state and output decode; tx_start/req_ready/ticks are single-cycle
   // pulses derived from registered state plus the owner's inputs.
   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant_r;
      gidx_nxt      = gidx;
      rr_nxt        = rr_ptr;
      idle_nxt      = idle_cnt;
      last_nxt      = last_r;
      tx_start      = 1'b0;
      tx_data       = '0;
      req_ready     = '0;
      pkt_done_tick = 1'b0;
      timeout_tick  = 1'b0;

      case (state)
         S_IDLE: begin
            if (pick_found) begin
               grant_nxt = NUM_REQ'(1) << pick_idx;
               gidx_nxt  = pick_idx;
               idle_nxt  = '0;
               state_nxt = S_SEND;
            end
         end

         S_SEND: begin
            tx_data = sel_data;
            if (sel_valid && !tx_busy) begin
               tx_start  = 1'b1;
               req_ready = grant_r;
               last_nxt  = sel_last;
               idle_nxt  = '0;
               state_nxt = S_WAIT_BUSY;
            end else if (!sel_valid) begin
               if ((TIMEOUT != 0) && (idle_cnt == CNT_LAST)) begin
                  timeout_tick  = 1'b1;
                  pkt_done_tick = 1'b1;
                  rr_nxt        = next_ptr;
                  grant_nxt     = '0;
                  idle_nxt      = '0;
                  state_nxt     = S_IDLE;
               end else begin
                  idle_nxt = idle_cnt + CW'(1);
               end
            end
         end

         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_nxt = S_WAIT_DONE;
            end
         end

         S_WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_r) begin
                  pkt_done_tick = 1'b1;
                  rr_nxt        = next_ptr;
                  grant_nxt     = '0;
                  state_nxt     = S_IDLE;
               end else begin
                  state_nxt = S_SEND;
               end
            end
         end

         default: begin
            state_nxt = S_IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   // State and datapath registers; async reset abandons any packet in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         grant_r  <= '0;
         gidx     <= '0;
         rr_ptr   <= '0;
         idle_cnt <= '0;
         last_r   <= 1'b0;
      end else begin
         state    <= state_nxt;
         grant_r  <= grant_nxt;
         gidx     <= gidx_nxt;
         rr_ptr   <= rr_nxt;
         idle_cnt <= idle_nxt;
         last_r   <= last_nxt;
      end
   end

endmodule
